// File: rtl/limn2600_bus_pkg.sv
// Shared definitions for the Limn2600 SRAM bus arbiter: FSM encoding and default watchdog limit.
package limn2600_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } arb_state_e;

  localparam int unsigned DEF_TIMEOUT = 255;

endpackage

// File: rtl/limn2600_bus_arbiter_if.sv
// Bus bundle between the masters, the arbiter and the SRAM port.
interface limn2600_bus_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 32,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    m_cs;
  logic [NREQ-1:0]    m_we;
  logic [NREQ*AW-1:0] m_addr;
  logic [NREQ*DW-1:0] m_wdata;
  logic [NREQ-1:0]    m_rdy;
  logic               m_err;
  logic [DW-1:0]      m_rdata;
  logic [NREQ-1:0]    gnt;

  logic               s_cs;
  logic               s_we;
  logic [AW-1:0]      s_addr;
  logic [DW-1:0]      s_wdata;
  logic [DW-1:0]      s_rdata;
  logic               s_rdy;

  modport master (output m_cs, m_we, m_addr, m_wdata,
                  input  m_rdy, m_err, m_rdata, gnt);

  modport slave  (input  s_cs, s_we, s_addr, s_wdata,
                  output s_rdata, s_rdy);

  modport arb    (input  m_cs, m_we, m_addr, m_wdata, s_rdata, s_rdy,
                  output m_rdy, m_err, m_rdata, gnt,
                  output s_cs, s_we, s_addr, s_wdata);
endinterface

// File: rtl/limn2600_rr_picker.sv
// Combinational round-robin picker: first set request after 'last', wrapping mod NREQ.
module limn2600_rr_picker #(
  parameter  int NREQ = 2,
  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   win_idx
);

  int   idx;
  logic found;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    // Offset NREQ revisits 'last' itself, so a lone requester can win again.
    for (int off = 1; off <= NREQ; off++) begin
      idx = int'(last) + off;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        win[idx] = 1'b1;
        win_idx  = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/limn2600_bus_arbiter.sv
// Round-robin arbiter sharing the single SRAM port between NREQ masters, with a bus-error watchdog.
module limn2600_bus_arbiter
  import limn2600_bus_pkg::*;
#(
  parameter int          NREQ    = 2,
  parameter int          AW      = 32,
  parameter int          DW      = 32,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                   clk,
  input  logic                   rst,
  limn2600_bus_arbiter_if.arb    bus
);

  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW = $clog2(TIMEOUT + 1);

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [WDW-1:0]   wd_q, wd_d, wd_inc;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  m_rdy_q, m_rdy_d;
  logic             m_err_q, m_err_d;
  logic [DW-1:0]    m_rdata_q, m_rdata_d;
  logic             s_cs_q, s_cs_d;
  logic             s_we_q, s_we_d;
  logic [AW-1:0]    s_addr_q, s_addr_d;
  logic [DW-1:0]    s_wdata_q, s_wdata_d;

  logic [NREQ-1:0]  win;
  logic [IW-1:0]    win_idx;

  limn2600_rr_picker #(.NREQ(NREQ)) u_picker (
    .req     (bus.m_cs),
    .last    (last_q),
    .win     (win),
    .win_idx (win_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_q    <= IW'(NREQ - 1);
      wd_q      <= '0;
      gnt_q     <= '0;
      m_rdy_q   <= '0;
      m_err_q   <= 1'b0;
      m_rdata_q <= '0;
      s_cs_q    <= 1'b0;
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      gnt_q     <= gnt_d;
      m_rdy_q   <= m_rdy_d;
      m_err_q   <= m_err_d;
      m_rdata_q <= m_rdata_d;
      s_cs_q    <= s_cs_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
    end
  end

  assign wd_inc = wd_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    wd_d      = wd_q;
    gnt_d     = gnt_q;
    m_rdy_d   = m_rdy_q;
    m_err_d   = m_err_q;
    m_rdata_d = m_rdata_q;
    s_cs_d    = s_cs_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.m_cs) begin
          s_we_d    = bus.m_we[win_idx];
          s_addr_d  = bus.m_addr[int'(win_idx)*AW +: AW];
          s_wdata_d = bus.m_wdata[int'(win_idx)*DW +: DW];
          s_cs_d    = 1'b1;
          gnt_d     = win;
          last_d    = win_idx;
          wd_d      = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        // A ready SRAM beats the watchdog even on the final allowed cycle.
        if (bus.s_rdy) begin
          m_rdata_d = bus.s_rdata;
          m_rdy_d   = gnt_q;
          m_err_d   = 1'b0;
          s_cs_d    = 1'b0;
          state_d   = ACK;
        end else begin
          wd_d = wd_inc;
          if (wd_inc == WDW'(TIMEOUT)) begin
            m_rdata_d = '0;
            m_rdy_d   = gnt_q;
            m_err_d   = 1'b1;
            s_cs_d    = 1'b0;
            state_d   = ACK;
          end
        end
      end
      ACK: begin
        m_rdy_d = '0;
        m_err_d = 1'b0;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt     = gnt_q;
  assign bus.m_rdy   = m_rdy_q;
  assign bus.m_err   = m_err_q;
  assign bus.m_rdata = m_rdata_q;
  assign bus.s_cs    = s_cs_q;
  assign bus.s_we    = s_we_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_wdata = s_wdata_q;

endmodule

// File: doc/limn2600_bus_arbiter.md
# limn2600_bus_arbiter

Round-robin arbiter that shares the single Limn2600 SRAM port between up to NREQ bus masters (CPU, and later DMA/debug). It sits between the masters and the SRAM. Per grant it latches one request, drives the SRAM `cs/we/addr/data`, waits for SRAM `rdy`, and returns a one-cycle `rdy` to the winning master. A watchdog ends a transfer with a bus error if SRAM never answers.

## Interface
- `NREQ`, 2: number of masters (2..8).
- `AW`, 32: address width.
- `DW`, 32: data width.
- `TIMEOUT`, 255: max BUSY cycles waiting for `s_rdy` (≥1).
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `m_cs`  in  NREQ  per-master request; held high until that master's `m_rdy`.
- `m_we`  in  NREQ  per-master write enable.
- `m_addr`  in  NREQ*AW  packed addresses, master i at [i*AW +: AW].
- `m_wdata`  in  NREQ*DW  packed write data.
- `m_rdy`  out  NREQ  one-hot completion pulse.
- `m_err`  out  1  qualifies `m_rdy`: transfer timed out.
- `m_rdata`  out  DW  read data, shared; valid while any `m_rdy` is high.
- `gnt`  out  NREQ  one-hot current owner; 0 when idle.
- `s_cs`, `s_we`  out  1  SRAM select / write.
- `s_addr`  out  AW  SRAM address.
- `s_wdata`  out  DW  SRAM write data.
- `s_rdata`  in  DW  SRAM read data.
- `s_rdy`  in  1  SRAM transfer complete.

## Operation
- States: IDLE, BUSY, ACK.
- IDLE: if any `m_cs` is set, pick the winner round-robin. The search starts at `last+1` mod NREQ. At the edge, latch the winner's `we/addr/wdata` into the `s_*` registers, set `gnt`, set `s_cs=1`, set `last=winner`, clear the watchdog, and go to BUSY.
- BUSY: `s_*` outputs hold the latched values. Master input changes are ignored.
  - `s_rdy` sampled high: latch `s_rdata` into `m_rdata` (write: latched value don't-care), set `m_rdy[g]=1` and `m_err=0`, set `s_cs=0`, go to ACK.
  - Otherwise the watchdog increments. When it reaches TIMEOUT: set `m_rdy[g]=1`, `m_err=1`, `m_rdata=0`, `s_cs=0`, go to ACK.
- ACK: lasts exactly one cycle. At the next edge clear `m_rdy`, `m_err` and `gnt`, and go to IDLE. The master may keep `m_cs` high for a back-to-back request. That request arbitrates normally in IDLE, so the rotated pointer favours the others.
- Watchdog width is $clog2(TIMEOUT+1). It counts BUSY cycles without `s_rdy`. `s_rdy` on the TIMEOUT-th cycle wins over timeout.
- `s_rdy` outside BUSY is ignored.
- A master deasserting `m_cs` during BUSY does not abort the transfer. The SRAM access completes and `m_rdy` still pulses.
- Reset (async, `rst=0`) sets, immediately and without a clock:
  - state=IDLE, `last=NREQ-1` (so master 0 wins first);
  - `s_cs=s_we=0`, `s_addr=s_wdata=0`;
  - `m_rdy=0`, `m_err=0`, `m_rdata=0`, `gnt=0`, watchdog=0.
- Reset mid-BUSY abandons the transfer silently.

## Timing
- Cycle 0: IDLE, `m_cs[i]` high. Cycle 1: `s_cs` high, `gnt[i]` high.
- SRAM `rdy` at cycle 1+k (k≥0) gives `m_rdy[i]` at cycle 2+k. Minimum request-to-rdy latency is 2 cycles. Best back-to-back throughput is one transfer per 3 cycles.
- All outputs are registered; there is no combinational path from input to output.
- Timeout: `m_rdy`/`m_err` high in cycle 1+TIMEOUT.

## Structure
- Shared package `limn2600_bus_pkg`: state encoding (IDLE=2'd0, BUSY=2'd1, ACK=2'd2) and default TIMEOUT constant.
- Sub-module `limn2600_rr_picker`: combinational round-robin picker. Inputs are `req[NREQ]` and `last`. Outputs are one-hot `win` and a `win_idx` index. It is reused by future interrupt arbitration.

## Test plan
- Master 0 writes 0xDEADBEEF to 0x100, SRAM `rdy` in first BUSY cycle -> `s_cs`/`s_we` high with `s_addr=0x100`, `s_wdata=0xDEADBEEF` at cycle 1; `m_rdy=2'b01`, `m_err=0` at cycle 2; `gnt=0` at cycle 3.
- Master 1 reads 0x200, SRAM returns 0x12345678 with `rdy` 3 cycles after `s_cs` -> `m_rdy=2'b10`, `m_rdata=0x12345678` at cycle 5.
- Both masters request continuously from reset release -> grants alternate 0,1,0,1. No master gets two consecutive grants.
- TIMEOUT=8, SRAM never ready -> `m_rdy[g]=1`, `m_err=1`, `m_rdata=0` at cycle 9. `s_cs` low at cycle 9. Next request arbitrates normally.
- Master changes `m_addr` 0x100->0x300 and drops `m_cs` during BUSY -> `s_addr` stays 0x100. `m_rdy` still pulses on `s_rdy`.
- `rst` low mid-BUSY, between clock edges -> `s_cs`, `gnt`, `m_rdy` go 0 immediately. After release with both requesting, master 0 wins first.
